rv_test_monitor: RTL and testbench

Synthesizable self-check harness that sits beside the RV32I core (one or more harts) in simulation and FPGA bring-up builds. It sequences core reset and watches each hart's store port for writes to a `tohost` address. It decodes pass/fail codes, enforces a cycle timeout, and presents a sticky verdict plus a run-cycle count. It is parametrised in data width, hart count, reset length and timeout.

---
 rtl/rv_test_monitor_pkg.sv | 21 ++
 rtl/rv_test_monitor_if.sv | 12 +
 rtl/rv_test_monitor_decoder.sv | 28 ++
 rtl/rv_test_monitor.sv | 140 ++++++++++++++
 tb/tb_rv_test_monitor.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_test_monitor_pkg.sv
// Shared definitions for the tohost self-check monitor: FSM states, tohost
// encoding and the hart-index width helper.
package rv_test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam int unsigned PASS_CODE = 1;
  localparam int unsigned FAIL_BIT  = 0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_test_monitor_if.sv
// Per-hart store port bundle; hart i occupies bits [i*XLEN +: XLEN].
interface rv_test_monitor_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_HARTS = 1
);
  logic [NUM_HARTS-1:0]      st_valid;
  logic [NUM_HARTS*XLEN-1:0] st_addr;
  logic [NUM_HARTS*XLEN-1:0] st_data;

  modport master (output st_valid, st_addr, st_data);
  modport slave  (input  st_valid, st_addr, st_data);
endinterface

// File: rtl/rv_test_monitor_decoder.sv
// Combinational decode of one hart's store into tohost pass/fail events.
module rv_tohost_decoder
  import rv_test_monitor_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = 'h1000
) (
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            is_pass,
  output logic            is_fail,
  output logic [XLEN-1:0] code
);

  logic hit;
  logic is_pass_val;

  always_comb begin
    hit         = st_valid && (st_addr == TOHOST_ADDR);
    is_pass_val = (st_data == XLEN'(PASS_CODE));
    // Even values are syscall-proxy traffic and deliberately not decoded.
    is_pass     = hit && is_pass_val;
    is_fail     = hit && st_data[FAIL_BIT] && !is_pass_val;
    code        = st_data >> 1;
  end

endmodule

// File: rtl/rv_test_monitor.sv
// Core reset sequencer and tohost verdict monitor: FSM, reset/cycle counters,
// per-hart passed flags and lowest-index fail selection.
module rv_test_monitor
  import rv_test_monitor_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     NUM_HARTS      = 1,
  parameter int unsigned     RST_CYCLES     = 4,
  parameter int unsigned     TIMEOUT_CYCLES = 100000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned     CNT_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              cpurst,
  input  logic                              start,
  output logic [NUM_HARTS-1:0]              core_rst,
  rv_test_monitor_if.slave                  st,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [XLEN-1:0]                   fail_code,
  output logic [idx_width(NUM_HARTS)-1:0]   fail_hart,
  output logic [CNT_WIDTH-1:0]              cycle_count
);

  localparam int unsigned          HW       = idx_width(NUM_HARTS);
  localparam int unsigned          RW       = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]        RST_LAST = RW'(RST_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [RW-1:0]        rst_cnt;
  logic [NUM_HARTS-1:0] passed;

  logic [NUM_HARTS-1:0] hit_pass;
  logic [NUM_HARTS-1:0] hit_fail;
  logic [XLEN-1:0]      codes [NUM_HARTS];

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_dec
    rv_tohost_decoder #(
      .XLEN        (XLEN),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_dec (
      .st_valid (st.st_valid[g]),
      .st_addr  (st.st_addr[g*XLEN +: XLEN]),
      .st_data  (st.st_data[g*XLEN +: XLEN]),
      .is_pass  (hit_pass[g]),
      .is_fail  (hit_fail[g]),
      .code     (codes[g])
    );
  end

  logic [NUM_HARTS-1:0] passed_nxt;
  logic                 all_passed;
  logic                 any_fail;
  logic                 found;
  logic [HW-1:0]        fail_idx;
  logic [XLEN-1:0]      fail_val;

  always_comb begin
    passed_nxt = passed | hit_pass;
    all_passed = &passed_nxt;
    any_fail   = |hit_fail;
    found      = 1'b0;
    fail_idx   = '0;
    fail_val   = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (hit_fail[i] && !found) begin
        found    = 1'b1;
        fail_idx = HW'(i);
        fail_val = codes[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      core_rst    <= '1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      fail_hart   <= '0;
      cycle_count <= '0;
      passed      <= '0;
    end else begin
      case (state)
        // rst_cnt runs 0..RST_CYCLES so core_rst drops one edge after the
        // last held cycle, giving RST_CYCLES full edges of reset after start.
        ST_RESET: begin
          core_rst <= '1;
          if (rst_cnt == RST_LAST) begin
            state    <= ST_RUN;
            core_rst <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_count + CNT_WIDTH'(1);
          passed      <= passed_nxt;
          if (any_fail) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= fail_val;
            fail_hart <= fail_idx;
            core_rst  <= '1;
          end else if (all_passed) begin
            state    <= ST_PASS;
            done     <= 1'b1;
            pass     <= 1'b1;
            core_rst <= '1;
          end else if (cycle_count == CNT_LAST) begin
            state    <= ST_TIMEOUT;
            done     <= 1'b1;
            timeout  <= 1'b1;
            core_rst <= '1;
          end
        end
        default: begin
          core_rst <= '1;
          if (start) begin
            state       <= ST_RESET;
            rst_cnt     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
            fail_hart   <= '0;
            cycle_count <= '0;
            passed      <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_test_monitor.sv
// Scoreboard bench for rv_test_monitor: a 1-hart and a 4-hart instance driven
// with directed tohost stores; verdicts are popped when done rises.
module tb_rv_test_monitor;

  logic clk = 1'b0;
  logic cpurst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  always #5 clk = ~clk;

  rv_test_monitor_if #(.XLEN(32), .NUM_HARTS(1)) ifa ();
  rv_test_monitor_if #(.XLEN(32), .NUM_HARTS(4)) ifb ();

  logic        core_rst_a, done_a, pass_a, timeout_a;
  logic [31:0] fail_code_a, cycle_count_a;
  logic        fail_hart_a;

  logic [3:0]  core_rst_b;
  logic        done_b, pass_b, timeout_b;
  logic [31:0] fail_code_b, cycle_count_b;
  logic [1:0]  fail_hart_b;

  rv_test_monitor #(
    .XLEN(32), .NUM_HARTS(1), .RST_CYCLES(4), .TIMEOUT_CYCLES(20),
    .TOHOST_ADDR(32'h0000_1000), .CNT_WIDTH(32)
  ) dut_a (
    .clk(clk), .cpurst(cpurst), .start(start_a), .core_rst(core_rst_a), .st(ifa),
    .done(done_a), .pass(pass_a), .timeout(timeout_a), .fail_code(fail_code_a),
    .fail_hart(fail_hart_a), .cycle_count(cycle_count_a)
  );

  rv_test_monitor #(
    .XLEN(32), .NUM_HARTS(4), .RST_CYCLES(1), .TIMEOUT_CYCLES(50),
    .TOHOST_ADDR(32'h0000_1000), .CNT_WIDTH(32)
  ) dut_b (
    .clk(clk), .cpurst(cpurst), .start(start_b), .core_rst(core_rst_b), .st(ifb),
    .done(done_b), .pass(pass_b), .timeout(timeout_b), .fail_code(fail_code_b),
    .fail_hart(fail_hart_b), .cycle_count(cycle_count_b)
  );

  typedef struct {
    logic        p;
    logic        t;
    logic [31:0] code;
    logic [31:0] hart;
    logic [31:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic t, input logic [31:0] code,
                              input logic [31:0] hart, input logic [31:0] cnt);
    exp_t e;
    e.p = p; e.t = t; e.code = code; e.hart = hart; e.cnt = cnt;
    return e;
  endfunction

  // Monitors: one verdict expected per rising edge of done.
  logic da_prev = 1'b0;
  logic db_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done_a && !da_prev) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_verdict: got unexpected done expected no verdict (t=%0t)", $time);
      end else begin
        e = qa.pop_front();
        chk("a_pass",      32'(pass_a),      32'(e.p));
        chk("a_timeout",   32'(timeout_a),   32'(e.t));
        chk("a_fail_code", fail_code_a,      e.code);
        chk("a_fail_hart", 32'(fail_hart_a), e.hart);
        chk("a_cycles",    cycle_count_a,    e.cnt);
      end
    end
    da_prev = done_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b && !db_prev) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_verdict: got unexpected done expected no verdict (t=%0t)", $time);
      end else begin
        e = qb.pop_front();
        chk("b_pass",      32'(pass_b),      32'(e.p));
        chk("b_timeout",   32'(timeout_b),   32'(e.t));
        chk("b_fail_code", fail_code_b,      e.code);
        chk("b_fail_hart", 32'(fail_hart_b), e.hart);
        chk("b_cycles",    cycle_count_b,    e.cnt);
      end
    end
    db_prev = done_b;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge where cycle_count reads 0 in RUN.
  task automatic start_a_run();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("a_start_done", 32'(done_a), 32'd0);
    chk("a_start_pass", 32'(pass_a), 32'd0);
    chk("a_start_cnt",  cycle_count_a, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("a_rst_hold", 32'(core_rst_a), 32'd1);
    end
    @(negedge clk);
    chk("a_rst_release", 32'(core_rst_a), 32'd0);
    chk("a_run_cnt0",    cycle_count_a,   32'd0);
  endtask

  task automatic start_b_run();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    chk("b_start_done", 32'(done_b), 32'd0);
    @(negedge clk);
    chk("b_rst_hold", 32'(core_rst_b), 32'hF);
    @(negedge clk);
    chk("b_rst_release", 32'(core_rst_b), 32'h0);
  endtask

  task automatic store_a(input logic [31:0] addr, input logic [31:0] data);
    ifa.st_valid = 1'b1;
    ifa.st_addr  = addr;
    ifa.st_data  = data;
    @(negedge clk);
    ifa.st_valid = 1'b0;
    ifa.st_data  = '0;
  endtask

  task automatic store_b(input logic [3:0] v, input logic [31:0] d3, input logic [31:0] d2,
                         input logic [31:0] d1, input logic [31:0] d0);
    ifb.st_valid = v;
    ifb.st_addr  = {4{32'h0000_1000}};
    ifb.st_data  = {d3, d2, d1, d0};
    @(negedge clk);
    ifb.st_valid = '0;
    ifb.st_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.st_valid = '0; ifa.st_addr = '0; ifa.st_data = '0;
    ifb.st_valid = '0; ifb.st_addr = '0; ifb.st_data = '0;
    cyc(2);
    cpurst = 1'b0;
    chk("rst_core_rst_a", 32'(core_rst_a), 32'd1);
    chk("rst_done_a",     32'(done_a),     32'd0);
    chk("rst_pass_a",     32'(pass_a),     32'd0);
    chk("rst_timeout_a",  32'(timeout_a),  32'd0);
    chk("rst_code_a",     fail_code_a,     32'd0);
    chk("rst_count_a",    cycle_count_a,   32'd0);
    chk("rst_core_rst_b", 32'(core_rst_b), 32'hF);
    chk("rst_hart_b",     32'(fail_hart_b), 32'd0);

    // Single-hart pass at RUN cycle 10 with ignored even and off-address stores.
    start_a_run();
    cyc(1); chk("a_count1", cycle_count_a, 32'd1);
    cyc(1); chk("a_count2", cycle_count_a, 32'd2);
    cyc(1); chk("a_count3", cycle_count_a, 32'd3);
    store_a(32'h1000, 32'h2);
    store_a(32'h1004, 32'h1);
    cyc(4);
    qa.push_back(mk(1'b1, 1'b0, 32'h0, 32'd0, 32'd10));
    store_a(32'h1000, 32'h1);
    chk("a_pass_core_rst", 32'(core_rst_a), 32'd1);
    store_a(32'h1000, 32'h3);
    chk("a_term_ignore_code", fail_code_a, 32'd0);
    chk("a_term_ignore_pass", 32'(pass_a), 32'd1);

    // Restart from PASS, then timeout with no stores.
    start_a_run();
    qa.push_back(mk(1'b0, 1'b1, 32'h0, 32'd0, 32'd20));
    cyc(25);
    chk("a_count_frozen", cycle_count_a, 32'd20);
    chk("a_to_core_rst",  32'(core_rst_a), 32'd1);

    // Fail store in the last cycle wins over timeout.
    start_a_run();
    cyc(19);
    qa.push_back(mk(1'b0, 1'b0, 32'h2A, 32'd0, 32'd20));
    store_a(32'h1000, 32'h55);
    chk("a_fail_not_to", 32'(timeout_a), 32'd0);

    // Abort mid-run.
    start_a_run();
    cyc(5);
    cpurst = 1'b1;
    @(negedge clk);
    cpurst = 1'b0;
    chk("a_abort_core_rst", 32'(core_rst_a), 32'd1);
    chk("a_abort_count",    cycle_count_a,   32'd0);
    chk("a_abort_done",     32'(done_a),     32'd0);

    // Four harts: harts 3 and 1 fail together; lowest index reported.
    start_b_run();
    cyc(2);
    qb.push_back(mk(1'b0, 1'b0, 32'h5, 32'd1, 32'd3));
    store_b(4'b1010, 32'h7, 32'h0, 32'hB, 32'h0);

    // Staggered passes, including an idempotent repeat.
    start_b_run();
    cyc(4);
    store_b(4'b0001, 32'h0, 32'h0, 32'h0, 32'h1);
    cyc(1);
    store_b(4'b0100, 32'h0, 32'h1, 32'h0, 32'h0);
    store_b(4'b1000, 32'h1, 32'h0, 32'h0, 32'h0);
    store_b(4'b0001, 32'h0, 32'h0, 32'h0, 32'h1);
    chk("b_not_done_partial", 32'(done_b), 32'd0);
    qb.push_back(mk(1'b1, 1'b0, 32'h0, 32'd0, 32'd10));
    store_b(4'b0010, 32'h0, 32'h0, 32'h1, 32'h0);

    // Completing pass and a fail in the same cycle: fail takes precedence.
    start_b_run();
    store_b(4'b1100, 32'h1, 32'h1, 32'h0, 32'h0);
    qb.push_back(mk(1'b0, 1'b0, 32'h4, 32'd0, 32'd2));
    store_b(4'b0011, 32'h0, 32'h0, 32'h1, 32'h9);

    // A hart that already passed can still fail later.
    start_b_run();
    store_b(4'b0001, 32'h0, 32'h0, 32'h0, 32'h1);
    qb.push_back(mk(1'b0, 1'b0, 32'h1, 32'd0, 32'd2));
    store_b(4'b0001, 32'h0, 32'h0, 32'h0, 32'h3);

    cyc(3);
    chk("a_pending", 32'(qa.size()), 32'd0);
    chk("b_pending", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
